// File: rtl/trng_ctrl.sv
// Sequencing controller for the ring-oscillator entropy source: warm-up discard,
// repetition-count health test, optional von Neumann debiasing and byte delivery.
module trng_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int REP_LIMIT     = 16,
  parameter bit DEBIAS        = 1'b1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       enable,
  input  logic       clear_fail,
  input  logic       raw_bit,
  input  logic       raw_valid,
  output logic       src_en,
  output logic [7:0] rand_byte,
  output logic       rand_valid,
  input  logic       rand_ready,
  output logic       busy,
  output logic       health_fail
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WARMUP  = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] FAIL    = 3'd4;

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

  logic [2:0]    state;
  logic [WW-1:0] warm_cnt;
  logic [RW-1:0] run_cnt;
  logic          prev_bit;
  logic          pair_full;
  logic          pair_bit;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;

  logic          sampling;
  logic [RW-1:0] run_next;
  logic          trip;
  logic          out_valid;
  logic          out_bit;
  logic          byte_done;

  assign sampling = raw_valid && enable && (state == WARMUP || state == COLLECT);

  // A run count of zero marks the first sample since WARMUP was entered.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    run_next = RW'(1);
    if (run_cnt != '0 && raw_bit == prev_bit)
      run_next = (run_cnt == REP_MAX) ? run_cnt : run_cnt + 1'b1;
  end

  assign trip = sampling && (run_next == REP_MAX);

  always_comb begin
    out_valid = 1'b0;
    out_bit   = raw_bit;
    if (sampling && state == COLLECT) begin
      if (!DEBIAS) begin
        out_valid = 1'b1;
      end else if (pair_full && pair_bit != raw_bit) begin
        out_valid = 1'b1;
        out_bit   = pair_bit;
      end
    end
  end

  // A health trip on the completing sample suppresses the byte.
  assign byte_done = out_valid && !trip && (bit_cnt == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      warm_cnt  <= '0;
      run_cnt   <= '0;
      prev_bit  <= 1'b0;
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
      shift     <= 8'h00;
      bit_cnt   <= 3'd0;
      rand_byte <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= WARMUP;
            warm_cnt <= '0;
            run_cnt  <= '0;
            bit_cnt  <= 3'd0;
          end
        end
        WARMUP: begin
          if (!enable) begin
            state <= IDLE;
          end else if (raw_valid) begin
            run_cnt  <= run_next;
            prev_bit <= raw_bit;
            if (trip) begin
              state <= FAIL;
            end else if (warm_cnt == WARM_LAST) begin
              state     <= COLLECT;
              pair_full <= 1'b0;
            end else begin
              warm_cnt <= warm_cnt + 1'b1;
            end
          end
        end
        COLLECT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (raw_valid) begin
            run_cnt  <= run_next;
            prev_bit <= raw_bit;
            pair_bit <= raw_bit;
            if (DEBIAS) pair_full <= !pair_full;
            if (trip) begin
              state <= FAIL;
            end else if (out_valid) begin
              shift   <= {shift[6:0], out_bit};
              bit_cnt <= bit_cnt + 1'b1;
              if (byte_done) begin
                rand_byte <= {shift[6:0], out_bit};
                state     <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (rand_ready) begin
            state     <= enable ? COLLECT : IDLE;
            pair_full <= 1'b0;
          end
        end
        FAIL: begin
          if (clear_fail) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign src_en      = (state == WARMUP) || (state == COLLECT) || (state == HOLD);
  assign busy        = src_en;
  assign rand_valid  = (state == HOLD);
  assign health_fail = (state == FAIL);

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_trng_ctrl;

  localparam int WARMUP = 4;
  localparam int REP    = 8;

  logic       clk = 1'b0;
  logic       n_reset, enable, clear_fail, raw_bit, raw_valid, rand_ready;
  logic       src_en, rand_valid, busy, health_fail;
  logic [7:0] rand_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trng_ctrl #(.WARMUP_CYCLES(WARMUP), .REP_LIMIT(REP), .DEBIAS(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .enable(enable), .clear_fail(clear_fail),
    .raw_bit(raw_bit), .raw_valid(raw_valid), .src_en(src_en),
    .rand_byte(rand_byte), .rand_valid(rand_valid), .rand_ready(rand_ready),
    .busy(busy), .health_fail(health_fail)
  );

  // Behavioural model: history window for the health test, pair and bit queues.
  typedef enum {M_IDLE, M_WARM, M_COLL, M_HOLD, M_FAIL} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_warm;
  bit         m_hist[$];
  bit         m_pair[$];
  bit         m_bits[$];
  logic [7:0] m_byte = 8'h00;

  function automatic bit health_trip(bit b);
    m_hist.push_back(b);
    if (m_hist.size() > REP) void'(m_hist.pop_front());
    if (m_hist.size() < REP) return 1'b0;
    foreach (m_hist[i]) if (m_hist[i] != b) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [7:0] packed_b;
    if (!n_reset) begin
      m_mode = M_IDLE; m_byte = 8'h00; m_warm = 0;
      m_hist.delete(); m_pair.delete(); m_bits.delete();
      return;
    end
    case (m_mode)
      M_IDLE: if (enable) begin
        m_mode = M_WARM; m_warm = 0; m_hist.delete(); m_bits.delete();
      end
      M_WARM: if (!enable) m_mode = M_IDLE;
        else if (raw_valid) begin
          if (health_trip(raw_bit)) m_mode = M_FAIL;
          else begin
            m_warm++;
            if (m_warm == WARMUP) begin m_mode = M_COLL; m_pair.delete(); end
          end
        end
      M_COLL: if (!enable) m_mode = M_IDLE;
        else if (raw_valid) begin
          if (health_trip(raw_bit)) m_mode = M_FAIL;
          else begin
            m_pair.push_back(raw_bit);
            if (m_pair.size() == 2) begin
              if (m_pair[0] != m_pair[1]) m_bits.push_back(m_pair[0]);
              m_pair.delete();
            end
            if (m_bits.size() == 8) begin
              foreach (m_bits[i]) packed_b[7-i] = m_bits[i];
              m_byte = packed_b; m_bits.delete(); m_mode = M_HOLD;
            end
          end
        end
      M_HOLD: if (rand_ready) begin
        m_mode = enable ? M_COLL : M_IDLE; m_pair.delete();
      end
      M_FAIL: if (clear_fail) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock: update the model from the inputs the DUT is about to sample, then compare.
  task automatic cycle();
    logic [11:0] got, exp;
    bit act;
    model_step();
    @(posedge clk);
    #1;
    act = (m_mode == M_WARM) || (m_mode == M_COLL) || (m_mode == M_HOLD);
    exp = {act, act, (m_mode == M_HOLD), (m_mode == M_FAIL), m_byte};
    got = {src_en, busy, rand_valid, health_fail, rand_byte};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cycle @%0t: {src_en,busy,valid,fail,byte} got %h expected %h", $time, got, exp);
    end
  endtask

  task automatic drive(bit v, bit b);
    raw_valid = v; raw_bit = b; cycle();
  endtask

  task automatic do_warmup();
    for (int i = 0; i < WARMUP; i++) drive(1'b1, (i % 2) == 0);
  endtask

  task automatic send_byte_pairs(logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, b[i]);
      drive(1'b1, !b[i]);
    end
  endtask

  task automatic handshake_and_disable();
    raw_valid = 1'b0; rand_ready = 1'b1; cycle();
    rand_ready = 1'b0; enable = 1'b0; cycle();
  endtask

  // Sends a sample sequence that must complete 8'hA5 exactly on its last sample.
  task automatic send_a5_seq(string name, bit s[$]);
    for (int i = 0; i < s.size(); i++) begin
      drive(1'b1, s[i]);
      if (i == s.size() - 2) begin
        checks++;
        if (rand_valid !== 1'b0) begin
          errors++; $display("FAIL %s_early_valid: got %b expected 0", name, rand_valid);
        end
      end
    end
    checks++;
    if (rand_valid !== 1'b1 || rand_byte !== 8'hA5) begin
      errors++;
      $display("FAIL %s_byte: got valid=%b byte=%h expected valid=1 byte=a5", name, rand_valid, rand_byte);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enable = 1'($urandom); raw_bit = 1'($urandom); raw_valid = 1'($urandom);
      rand_ready = 1'($urandom); clear_fail = 1'($urandom);
      cycle();
    end
    checks++;
    if ({src_en, rand_valid, health_fail, busy, rand_byte} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got en=%b v=%b f=%b busy=%b byte=%h expected all zero",
               src_en, rand_valid, health_fail, busy, rand_byte);
    end
    n_reset = 1'b1; enable = 1'b0; raw_valid = 1'b0; raw_bit = 1'b0;
    rand_ready = 1'b0; clear_fail = 1'b0;
    cycle();
  endtask

  task automatic test_debias_a5();
    bit s[$] = '{1,0, 0,1, 1,0, 0,1, 0,1, 1,0, 0,1, 1,0};
    enable = 1'b1; raw_valid = 1'b0; cycle();
    checks++;
    if (src_en !== 1'b1) begin
      errors++; $display("FAIL src_en_after_enable: got %b expected 1", src_en);
    end
    do_warmup();
    send_a5_seq("debias_a5", s);
    handshake_and_disable();
  endtask

  task automatic test_discard_pairs();
    bit s[$] = '{1,0, 0,0, 0,1, 1,1, 1,0, 0,1, 0,0, 0,1, 1,1, 1,0, 0,1, 0,0, 1,0};
    enable = 1'b1; raw_valid = 1'b0; cycle();
    do_warmup();
    send_a5_seq("discard_pairs", s);
    handshake_and_disable();
  endtask

  task automatic test_backpressure();
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    enable = 1'b1; raw_valid = 1'b0; cycle();
    do_warmup();
    send_byte_pairs(b1);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom));
      checks++;
      if (rand_valid !== 1'b1 || rand_byte !== b1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got valid=%b byte=%h expected valid=1 byte=%h", i, rand_valid, rand_byte, b1);
      end
    end
    raw_valid = 1'b0; rand_ready = 1'b1; cycle();
    rand_ready = 1'b0;
    checks++;
    if (rand_valid !== 1'b0) begin
      errors++; $display("FAIL handshake_clear: got %b expected 0", rand_valid);
    end
    send_byte_pairs(b2);
    checks++;
    if (rand_valid !== 1'b1 || rand_byte !== b2) begin
      errors++; $display("FAIL second_byte: got valid=%b byte=%h expected valid=1 byte=%h", rand_valid, rand_byte, b2);
    end
    handshake_and_disable();
  endtask

  task automatic test_health_fail();
    enable = 1'b1; raw_valid = 1'b0; cycle();
    do_warmup();
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1);
    checks++;
    if (health_fail !== 1'b0) begin
      errors++; $display("FAIL health_early: got %b expected 0", health_fail);
    end
    drive(1'b1, 1'b1);
    checks++;
    if ({health_fail, src_en, rand_valid, busy} !== 4'b1000) begin
      errors++; $display("FAIL health_trip: got fail,en,valid,busy=%b expected 1000",
                         {health_fail, src_en, rand_valid, busy});
    end
    raw_valid = 1'b0; clear_fail = 1'b1; cycle();
    clear_fail = 1'b0;
    checks++;
    if ({health_fail, src_en} !== 2'b00) begin
      errors++; $display("FAIL clear_fail_idle: got fail,en=%b expected 00", {health_fail, src_en});
    end
    cycle();
    checks++;
    if ({src_en, busy} !== 2'b11) begin
      errors++; $display("FAIL rewarm_after_clear: got en,busy=%b expected 11", {src_en, busy});
    end
    enable = 1'b0; cycle();
  endtask

  task automatic test_enable_drop();
    logic [7:0] b3;
    b3 = 8'($urandom);
    enable = 1'b1; raw_valid = 1'b0; cycle();
    do_warmup();
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    drive(1'b1, 1'b0); drive(1'b1, 1'b1);
    drive(1'b1, 1'b1); drive(1'b1, 1'b0);
    enable = 1'b0; raw_valid = 1'b0; cycle();
    checks++;
    if ({src_en, busy} !== 2'b00) begin
      errors++; $display("FAIL drop_to_idle: got en,busy=%b expected 00", {src_en, busy});
    end
    enable = 1'b1; cycle();
    do_warmup();
    send_byte_pairs(b3);
    checks++;
    if (rand_valid !== 1'b1 || rand_byte !== b3) begin
      errors++; $display("FAIL fresh_byte_after_drop: got valid=%b byte=%h expected valid=1 byte=%h", rand_valid, rand_byte, b3);
    end
    enable = 1'b0; raw_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    checks++;
    if (rand_valid !== 1'b1 || rand_byte !== b3) begin
      errors++; $display("FAIL hold_survives_disable: got valid=%b byte=%h expected valid=1 byte=%h", rand_valid, rand_byte, b3);
    end
    rand_ready = 1'b1; cycle();
    rand_ready = 1'b0;
    checks++;
    if ({rand_valid, src_en, busy} !== 3'b000) begin
      errors++; $display("FAIL hold_to_idle: got valid,en,busy=%b expected 000", {rand_valid, src_en, busy});
    end
  endtask

  task automatic test_random();
    bit last = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      n_reset    = ($urandom_range(0, 499) != 0);
      enable     = ($urandom_range(0, 39) != 0);
      clear_fail = ($urandom_range(0, 7) == 0);
      rand_ready = 1'($urandom);
      raw_valid  = ($urandom_range(0, 3) != 0);
      raw_bit    = ($urandom_range(0, 9) < 7) ? last : 1'($urandom);
      last       = raw_bit;
      cycle();
    end
    n_reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debias_a5();
    test_discard_pairs();
    test_backpressure();
    test_health_fail();
    test_enable_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
Sequencing controller for the ring-oscillator entropy source. It gates the source and discards a warm-up window. It runs a repetition-count health test on the raw bit stream, optionally applies von Neumann debiasing, and assembles debiased bits into bytes. Bytes are delivered to one consumer over a valid/ready handshake. Sits between the entropy source and any key/nonce consumer.

Parameters:
WARMUP_CYCLES, 64, number of accepted raw samples discarded after enable before collection starts (>=1)
REP_LIMIT, 16, consecutive identical raw samples that trip the health test (>=2)
DEBIAS, 1, 1 = von Neumann pair debiasing; 0 = raw bits used directly

Ports:
clk  input  1  system clock
n_reset  input  1  reset, synchronous, active-low
enable  input  1  level; 1 = run generator
clear_fail  input  1  pulse; exits FAIL state
raw_bit  input  1  sample from entropy source
raw_valid  input  1  raw_bit valid this cycle
src_en  output  1  enables entropy source
rand_byte  output  8  assembled random byte
rand_valid  output  1  rand_byte valid
rand_ready  input  1  consumer accepts byte
busy  output  1  1 in WARMUP/COLLECT/HOLD
health_fail  output  1  sticky health-test failure flag

Behaviour:
- All state registered on posedge clk. n_reset=0: state IDLE; src_en, rand_valid, busy, health_fail = 0; rand_byte = 8'h00; shift register, bit count, warm-up count, run count and pair latch all cleared. Reset mid-operation discards everything, including any pending byte.
- States: IDLE, WARMUP, COLLECT, HOLD, FAIL. Outputs are decoded from registered state, so there is no comb path from inputs to outputs.
- IDLE: src_en=0. When enable=1, go to WARMUP and clear the warm-up count.
- WARMUP: src_en=1. Each raw_valid increments the warm-up count, and the sample goes to the health test only. After the WARMUP_CYCLES-th sample, go to COLLECT. enable=0 goes to IDLE.
- COLLECT: src_en=1. Each raw_valid sample goes to the health test and the debiaser.
- DEBIAS=1:
  - First sample of a pair is latched.
  - On the second sample: 1,0 gives output bit 1; 0,1 gives output bit 0; 0,0 or 1,1 is discarded.
  - Pairing restarts on entry to COLLECT.
- DEBIAS=0: every sample is an output bit.
- Output bits shift into the LSB: shift <= {shift[6:0], bit}. The first bit ends in rand_byte[7].
- On the 8th bit: rand_byte <= completed byte, rand_valid=1 from the next cycle, go to HOLD. enable=0 in COLLECT goes to IDLE and drops the partial byte.
- HOLD: rand_byte and rand_valid are held stable. Raw samples are ignored by both the health test and the debiaser, and src_en stays 1.
  - Handshake (rand_valid & rand_ready) clears rand_valid next cycle.
  - After the handshake, go to COLLECT if enable=1, else IDLE.
  - enable=0 never withdraws a pending byte.
- Health test (WARMUP and COLLECT only):
  - run count = 1 on the first sample after entering WARMUP, or when a sample differs from the previous one.
  - Otherwise run count increments, saturating.
  - When the count reaches REP_LIMIT, go to FAIL next cycle.
  - Priority: health failure beats byte completion in the same cycle, so no byte is emitted.
- FAIL: src_en=0, rand_valid=0, busy=0, health_fail=1. Partial byte discarded. clear_fail=1 goes to IDLE and clears health_fail. If enable is still 1, WARMUP follows the cycle after.
- clear_fail is ignored outside FAIL.
- Byte latency: rand_valid asserts 1 cycle after the cycle carrying the completing raw sample.

Test Plan:
- Reset: n_reset=0 for 2 cycles with inputs toggling -> src_en=0, rand_valid=0, rand_byte=8'h00, health_fail=0, busy=0.
- WARMUP_CYCLES=4, DEBIAS=1: enable=1, 4 warm-up samples, then pairs 10,01,10,01,01,10,01,10 -> rand_byte=8'hA5, rand_valid=1 one cycle after the 16th collected sample. src_en=1 from the cycle after enable.
- Same stimulus with 00 and 11 pairs interleaved -> still 8'hA5, after the same number of useful pairs.
- rand_ready=0 for 20 cycles with raw stream running -> rand_byte stable, rand_valid=1. The next byte is built only from samples after the handshake.
- REP_LIMIT=8: 8 consecutive raw 1s in COLLECT -> health_fail=1, src_en=0, no byte output. clear_fail pulse -> IDLE, health_fail=0. With enable held, WARMUP restarts.
- enable=0 after 3 collected bits -> IDLE next cycle, partial byte lost. Re-enable redoes warm-up. enable=0 in HOLD -> byte still delivered on rand_ready, then IDLE.
